fc_layer_scheduler: RTL and testbench
=====================================

FC_LAYER_SCHEDULER -- requirements
Module: fc_layer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 2, meaning the number of fully connected layers run per inference on one shared FullyConnected engine.
REQ-002 The block SHALL have parameter OUT_SIZE, default 10, meaning the number of final-layer scores (classes).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the signed score width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum wait per layer for fc_done.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit, which requests an inference.
REQ-008 The block SHALL have port busy, output, 1 bit, high in every state except IDLE and ERR.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when class_out is valid.
REQ-010 The block SHALL have port error, output, 1 bit, a sticky timeout flag.
REQ-011 The block SHALL have port layer_sel, output, $clog2(NUM_LAYERS) bits, which selects the weight/bias bank and input mux of the engine.
REQ-012 The block SHALL have port fc_start, output, 1 bit, the engine start pulse.
REQ-013 The block SHALL have port fc_done, input, 1 bit, the engine completion.
REQ-014 The block SHALL have port score_addr, output, $clog2(OUT_SIZE) bits, which is the score buffer read address.
REQ-015 The block SHALL have port score_data, input, signed DATA_WIDTH bits, the score read data, valid one cycle after score_addr.
REQ-016 The block SHALL have port class_out, output, $clog2(OUT_SIZE) bits, the argmax result.

Function
REQ-017 The FSM SHALL use states IDLE, LAUNCH, WAIT, SCAN, DRAIN, DONE, ERR.
REQ-018 In IDLE, start=1 SHALL set layer_sel=0 and move to LAUNCH; start=0 SHALL keep the FSM in IDLE.
REQ-019 In LAUNCH, fc_start SHALL be 1 for exactly that one cycle, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-020 In WAIT, when fc_done=1 and layer_sel<NUM_LAYERS-1, layer_sel SHALL increment and the next state SHALL be LAUNCH.
REQ-021 In WAIT, when fc_done=1 and layer_sel=NUM_LAYERS-1, score_addr SHALL be 0 and the next state SHALL be SCAN.
REQ-022 In WAIT, the counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES-1 with fc_done=0, the next state SHALL be ERR.
REQ-023 If fc_done=1 arrives in that same final cycle, fc_done SHALL win and no error SHALL be raised.
REQ-024 fc_done SHALL be ignored in all states other than WAIT.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 In SCAN, score_addr SHALL step 0..OUT_SIZE-1, one per cycle; after address OUT_SIZE-1 the next state SHALL be DRAIN for one cycle to capture the last datum.
REQ-027 The first returned score SHALL initialise best value and index.
REQ-028 Each later score SHALL replace the best only if signed strictly greater, so ties keep the lowest index.
REQ-029 In DONE, done=1 for one cycle, class_out SHALL update in that same cycle, and the next state SHALL be IDLE.
REQ-030 class_out SHALL hold until the next DONE.
REQ-031 Latency: fc_start SHALL be high in the cycle after start is sampled.
REQ-032 Latency: each next-layer fc_start SHALL be high in the cycle after fc_done is sampled.
REQ-033 Latency: done SHALL assert OUT_SIZE+2 cycles after fc_done is sampled for the last layer.
REQ-034 ERR SHALL hold error=1 and busy=0; the FSM SHALL leave ERR only on rst or start.
REQ-035 start in ERR SHALL clear error, set layer_sel=0, and move to LAUNCH.
REQ-036 Comparisons SHALL be full DATA_WIDTH signed; no truncation.

Reset
REQ-037 rst=1 at a clock edge SHALL force state IDLE.
REQ-038 rst=1 at a clock edge SHALL force busy, done, error, and fc_start to 0.
REQ-039 rst=1 at a clock edge SHALL force layer_sel, score_addr, class_out, the timeout counter, and the best registers to 0.
REQ-040 rst SHALL take priority over start and fc_done; a reset mid-run SHALL abort with no done pulse.

Verification (NUM_LAYERS=2, OUT_SIZE=10)
REQ-041 Normal run: engine model asserts fc_done 5 cycles after each fc_start; scores hold 77 at index 7, others below -> two fc_start pulses, layer_sel 0 then 1, one done with class_out=7 exactly 12 cycles after the second fc_done.
REQ-042 Ties/negatives: 50 at indices 2 and 6 -> class_out=2; scores -1,-2,...,-10 at indices 0..9 -> class_out=0; 0x7FFFFFFF at index 9 with 0x80000000 elsewhere -> 9.
REQ-043 Timeout: TIMEOUT_CYCLES=16, no fc_done for layer 1 -> error=1, busy=0, no done; then start -> error=0 next cycle and the run completes normally.
REQ-044 Timeout boundary: fc_done in the 16th WAIT cycle -> no error, run proceeds.
REQ-045 Spurious inputs: start pulsed in WAIT and SCAN, fc_done pulsed in IDLE and LAUNCH -> no extra fc_start, layer_sel unchanged, single done.
REQ-046 Reset mid-WAIT of layer 1 -> next cycle all outputs at reset values, no done; a fresh start then runs from layer_sel=0.

Source files
------------

// File: rtl/fc_layer_scheduler.sv
// Sequences NUM_LAYERS passes of a shared fully connected engine, then scans the
// final score buffer and reports the signed argmax as class_out.
module fc_layer_scheduler #(
  parameter int NUM_LAYERS     = 2,
  parameter int OUT_SIZE       = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [$clog2(NUM_LAYERS)-1:0]       layer_sel,
  output logic                                fc_start,
  input  logic                                fc_done,
  output logic [$clog2(OUT_SIZE)-1:0]         score_addr,
  input  logic signed [DATA_WIDTH-1:0]        score_data,
  output logic [$clog2(OUT_SIZE)-1:0]         class_out
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam int AW = $clog2(OUT_SIZE);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SCAN, DRAIN, DONE, ERR} state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          layer_q, layer_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic [AW-1:0]          best_idx_q, best_idx_d;
  logic [AW-1:0]          class_q, class_d;
  // Tracks which address the score buffer is returning this cycle.
  logic                   rd_vld_q, rd_vld_d;
  logic [AW-1:0]          rd_idx_q, rd_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    rd_vld_d   = (state_q == SCAN);
    rd_idx_d   = addr_q;

    // Index 0 seeds the running best; strict > keeps the lowest index on ties.
    if (rd_vld_q && ((rd_idx_q == '0) || (score_data > best_val_q))) begin
      best_val_d = score_data;
      best_idx_d = rd_idx_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          layer_d = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (fc_done) begin
          if (layer_q != LAST_LAYER) begin
            layer_d = layer_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            addr_d  = '0;
            state_d = SCAN;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = ERR;
        end
      end
      SCAN: begin
        if (addr_q == LAST_ADDR) state_d = DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      DRAIN: begin
        // Last datum lands now; publish the final winner so it is valid during DONE.
        class_d = best_idx_d;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      ERR: begin
        if (start) begin
          layer_d = '0;
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE) && (state_q != ERR);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign fc_start   = (state_q == LAUNCH);
  assign layer_sel  = layer_q;
  assign score_addr = addr_q;
  assign class_out  = class_q;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Scoreboard bench: stimulus pushes expected fc_start/done/error events, a
// forked monitor pops and compares them as the scheduler emits them.
module tb_fc_layer_scheduler;

  localparam int NL = 2;
  localparam int OS = 10;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int K_FCS  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int val;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, fc_start, fc_done;
  logic [$clog2(NL)-1:0] layer_sel;
  logic [$clog2(OS)-1:0] score_addr, class_out;
  logic signed [DW-1:0]  score_data = '0;

  logic signed [DW-1:0] scores [OS];
  logic eng_done  = 1'b0;
  logic spur_done = 1'b0;
  int   eng_cnt   = 0;
  int   eng_delay = 5;
  int   eng_skip  = -1;
  int   cyc  = 0;
  int   trig = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  assign fc_done = eng_done | spur_done;

  fc_layer_scheduler #(
    .NUM_LAYERS(NL), .OUT_SIZE(OS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .layer_sel(layer_sel), .fc_start(fc_start), .fc_done(fc_done),
    .score_addr(score_addr), .score_data(score_data), .class_out(class_out)
  );

  always #5 clk = ~clk;

  // Score buffer: one-cycle read latency.
  always @(posedge clk) score_data <= scores[score_addr];

  // Cycle stamp of the event that should trigger the next fc_start/done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((start && !busy) || (fc_done && busy)) trig <= cyc + 1;
  end

  // Engine model: fc_done eng_delay cycles after fc_start, unless layer is skipped.
  always @(negedge clk) begin
    eng_done <= (eng_cnt == 1);
    if (fc_start && (int'(layer_sel) != eng_skip)) eng_cnt <= eng_delay;
    else if (eng_cnt > 0)                          eng_cnt <= eng_cnt - 1;
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic mon_evt(input int k, input int v);
    exp_t e;
    int lat;
    lat = cyc - trig + 1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none", k, v);
    end else begin
      e = sbq.pop_front();
      chk("evt_kind", k, e.kind);
      chk("evt_val", v, e.val);
      if (e.lat >= 0) chk("evt_latency", lat, e.lat);
    end
  endtask

  task automatic push_run(input int cls);
    sbq.push_back('{K_FCS, 0, 1});
    sbq.push_back('{K_FCS, 1, 1});
    sbq.push_back('{K_DONE, cls, OS + 2});
  endtask

  task automatic wait_done(input int bound);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_within_bound", int'(got), 1);
  endtask

  task automatic run(input int cls);
    push_run(cls);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("class_hold", int'(class_out), cls);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic peak7();
    for (int i = 0; i < OS; i++) scores[i] = -20 + i;
    scores[7] = 77;
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_fc_start", int'(fc_start), 0);
    chk("rst_layer_sel", int'(layer_sel), 0);
    chk("rst_score_addr", int'(score_addr), 0);
    chk("rst_class_out", int'(class_out), 0);
  endtask

  initial begin
    bit err_prev = 0;
    int ndone;
    bit got;
    for (int i = 0; i < OS; i++) scores[i] = '0;

    fork
      forever begin
        @(negedge clk);
        if (fc_start) mon_evt(K_FCS, int'(layer_sel));
        if (done)     mon_evt(K_DONE, int'(class_out));
        if (error && !err_prev) mon_evt(K_ERR, 0);
        err_prev = error;
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs();

    // Normal run and argmax patterns.
    peak7();
    run(7);
    for (int i = 0; i < OS; i++) scores[i] = 10;
    scores[2] = 50;
    scores[6] = 50;
    run(2);
    for (int i = 0; i < OS; i++) scores[i] = -(i + 1);
    run(0);
    for (int i = 0; i < OS; i++) scores[i] = 32'sh8000_0000;
    scores[9] = 32'sh7FFF_FFFF;
    run(9);

    // Timeout on layer 1, then recovery via start.
    eng_skip = 1;
    sbq.push_back('{K_FCS, 0, 1});
    sbq.push_back('{K_FCS, 1, 1});
    sbq.push_back('{K_ERR, 0, -1});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (error) got = 1;
    end
    chk("timeout_error", int'(error), 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_no_done", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("error_sticky", int'(error), 1);
    eng_skip = -1;
    peak7();
    push_run(7);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("error_cleared", int'(error), 0);
    wait_done(200);

    // fc_done in the final (16th) WAIT cycle must win.
    eng_delay = TO;
    run(7);
    chk("boundary_no_error", int'(error), 0);
    eng_delay = 5;

    // Spurious fc_done in IDLE/LAUNCH and start in WAIT/SCAN.
    @(negedge clk) spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_idle_busy", int'(busy), 0);
    push_run(7);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start     = (k == 0) || (k == 3) || (k == 15);
      spur_done = (k == 1);
      if (k == 4) chk("spur_layer_sel", int'(layer_sel), 0);
      if (done) ndone++;
    end
    start = 1'b0;
    spur_done = 1'b0;
    chk("spur_single_done", ndone, 1);

    // Reset in the middle of layer 1 WAIT.
    sbq.push_back('{K_FCS, 0, 1});
    sbq.push_back('{K_FCS, 1, 1});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k == 0);
      rst   = (k == 9);
    end
    chk("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run(7);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
